// File: rtl/larpix_pkg.sv
// Shared types and defaults for the PISO dispatch path.
package larpix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } disp_state_e;

  localparam int unsigned PKT_WIDTH_DEF   = 64;
  localparam int unsigned NUM_UARTS_DEF   = 4;
  localparam int unsigned ACK_TIMEOUT_DEF = 16;

  // Index width for a set of n items, never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first eligible lane at or after rr_ptr, wrapping.
module rr_priority_select #(
  parameter int unsigned NUM_UARTS = 4,
  parameter int unsigned LANE_W    = 2
) (
  input  logic [NUM_UARTS-1:0] eligible,
  input  logic [LANE_W-1:0]    rr_ptr,
  output logic                 grant_valid,
  output logic [LANE_W-1:0]    grant_idx
);

  logic [LANE_W-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_UARTS; k++) begin
      idx = LANE_W'((32'(rr_ptr) + k) % NUM_UARTS);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/piso_dispatcher.sv
// Dispatches event-FIFO packets to PISO UART lanes, one in flight, round-robin.
module piso_dispatcher
  import larpix_pkg::*;
#(
  parameter int unsigned WIDTH       = PKT_WIDTH_DEF,
  parameter int unsigned NUM_UARTS   = NUM_UARTS_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_UARTS-1:0] enable_piso,
  input  logic [WIDTH-1:0]     pkt_data,
  input  logic                 pkt_valid,
  output logic                 pkt_ready,
  input  logic [NUM_UARTS-1:0] tx_busy,
  output logic [WIDTH-1:0]     tx_data,
  output logic [NUM_UARTS-1:0] tx_load,
  output logic [15:0]          pkt_sent_count,
  output logic                 err_timeout,
  input  logic                 clr_err
);

  localparam int unsigned LANE_W = idx_bits(NUM_UARTS);
  localparam int unsigned TMO_W  = idx_bits(ACK_TIMEOUT + 1);

  disp_state_e           state_q, state_d;
  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [LANE_W-1:0]     rr_q, rr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [WIDTH-1:0]      tx_data_d;
  logic [NUM_UARTS-1:0]  tx_load_d;
  logic [15:0]           cnt_d;
  logic                  err_d;

  logic [NUM_UARTS-1:0]  eligible;
  logic                  grant_valid;
  logic [LANE_W-1:0]     grant_idx;
  logic [LANE_W-1:0]     lane_after;

  assign eligible   = enable_piso & ~tx_busy;
  assign pkt_ready  = reset_n & (state_q == ST_IDLE) & grant_valid;
  assign lane_after = (lane_q == LANE_W'(NUM_UARTS - 1)) ? '0 : lane_q + LANE_W'(1);

  rr_priority_select #(
    .NUM_UARTS (NUM_UARTS),
    .LANE_W    (LANE_W)
  ) u_sel (
    .eligible    (eligible),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state and datapath update; tx_load is high only for the LOAD cycle.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    rr_d      = rr_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data;
    tx_load_d = '0;
    cnt_d     = pkt_sent_count;
    err_d     = err_timeout & ~clr_err;

    case (state_q)
      ST_IDLE: begin
        if (pkt_valid && pkt_ready) begin
          tx_data_d = pkt_data;
          lane_d    = grant_idx;
          tx_load_d = NUM_UARTS'(1) << grant_idx;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmo_d   = '0;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (tx_busy[lane_q]) begin
          cnt_d   = pkt_sent_count + 16'd1;
          rr_d    = lane_after;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          // Drop the packet but still move the pointer past the silent lane.
          err_d   = 1'b1;
          rr_d    = lane_after;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      lane_q         <= '0;
      rr_q           <= '0;
      tmo_q          <= '0;
      tx_data        <= '0;
      tx_load        <= '0;
      pkt_sent_count <= '0;
      err_timeout    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lane_q         <= lane_d;
      rr_q           <= rr_d;
      tmo_q          <= tmo_d;
      tx_data        <= tx_data_d;
      tx_load        <= tx_load_d;
      pkt_sent_count <= cnt_d;
      err_timeout    <= err_d;
    end
  end

endmodule

// File: tb/tb_piso_dispatcher.sv
// Scoreboard bench for piso_dispatcher: stimulus pushes expected loads, a monitor pops them.
module tb_piso_dispatcher;

  typedef struct packed {
    logic [3:0]  load;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  enable_piso;
  logic [63:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  tx_busy;
  logic [63:0] tx_data;
  logic [3:0]  tx_load;
  logic [15:0] pkt_sent_count;
  logic        err_timeout;
  logic        clr_err;

  logic [3:0]  resp;
  logic [3:0]  hold_busy;
  int          busy_cnt [4];
  logic [3:0]  busy_model;

  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  piso_dispatcher dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_piso    (enable_piso),
    .pkt_data       (pkt_data),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .tx_busy        (tx_busy),
    .tx_data        (tx_data),
    .tx_load        (tx_load),
    .pkt_sent_count (pkt_sent_count),
    .err_timeout    (err_timeout),
    .clr_err        (clr_err)
  );

  // UART model: a responsive lane goes busy for 3 cycles after a load strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) busy_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (tx_load[i] && resp[i]) busy_cnt[i] <= 3;
        else if (busy_cnt[i] > 0)  busy_cnt[i] <= busy_cnt[i] - 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) busy_model[i] = (busy_cnt[i] != 0);
  end

  assign tx_busy = busy_model | hold_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a load strobe must match the next expected entry.
  always @(negedge clk) begin
    if (reset_n && tx_load != 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_load", 64'(tx_load), 64'h0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("load_lane", 64'(tx_load), 64'(e.load));
        chk("load_data", tx_data, e.data);
      end
    end
  end

  // Issues one packet expected on lane; returns just after the LOAD-cycle negedge.
  task automatic send(input logic [63:0] d, input int lane);
    exp_t e;
    bit   got;
    e.load       = 4'b0000;
    e.load[lane] = 1'b1;
    e.data       = d;
    sb_q.push_back(e);
    @(posedge clk); #1;
    pkt_data  = d;
    pkt_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (pkt_ready) got = 1'b1;
    end
    if (!got) chk("handshake_wait", 64'(pkt_ready), 64'h1);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    @(negedge clk);
    chk("load_latency", 64'(tx_load), 64'(e.load));
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset_n     = 1'b0;
    enable_piso = 4'b1111;
    pkt_data    = 64'h0;
    pkt_valid   = 1'b1;
    clr_err     = 1'b0;
    resp        = 4'b1111;
    hold_busy   = 4'b0000;

    // Reset state, with a valid packet and every lane free
    #12;
    chk("rst_ready",   64'(pkt_ready), 64'h0);
    chk("rst_load",    64'(tx_load), 64'h0);
    chk("rst_data",    tx_data, 64'h0);
    chk("rst_count",   64'(pkt_sent_count), 64'h0);
    chk("rst_err",     64'(err_timeout), 64'h0);
    pkt_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Four back-to-back packets rotate through lanes 0..3
    send(64'h1111_0000_0000_0001, 0);
    send(64'h2222_0000_0000_0002, 1);
    send(64'h3333_0000_0000_0003, 2);
    send(64'h4444_0000_0000_0004, 3);
    settle();
    chk("rr_count", 64'(pkt_sent_count), 64'd4);

    // Single enabled lane
    enable_piso = 4'b0010;
    send(64'hDEADBEEF_01234567, 1);
    @(negedge clk);
    chk("load_one_cycle", 64'(tx_load), 64'h0);
    chk("data_hold",      tx_data, 64'hDEADBEEF_01234567);
    settle();
    chk("single_count", 64'(pkt_sent_count), 64'd5);

    // All lanes disabled: no acceptance; enabling lane 0 opens ready at once
    enable_piso = 4'b0000;
    @(posedge clk); #1;
    pkt_data  = 64'hCAFE_F00D_0000_0050;
    pkt_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("disabled_ready", 64'(pkt_ready), 64'h0);
    end
    sb_q.push_back('{load: 4'b0001, data: 64'hCAFE_F00D_0000_0050});
    enable_piso = 4'b0001;
    #1;
    chk("enable_ready", 64'(pkt_ready), 64'h1);
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    settle();
    chk("enable_count", 64'(pkt_sent_count), 64'd6);

    // Lane 2 never acknowledges (rr_ptr is 1, lane 1 held busy)
    enable_piso = 4'b1111;
    hold_busy   = 4'b0010;
    resp        = 4'b1011;
    send(64'h5555_AAAA_5555_AAAA, 2);
    repeat (16) @(negedge clk);
    chk("tmo_early", 64'(err_timeout), 64'h0);
    @(negedge clk);
    chk("tmo_set",   64'(err_timeout), 64'h1);
    chk("tmo_count", 64'(pkt_sent_count), 64'd6);
    hold_busy = 4'b0000;
    resp      = 4'b1111;
    send(64'h6666_0000_0000_0006, 3);
    settle();
    chk("tmo_sticky", 64'(err_timeout), 64'h1);
    chk("after_tmo_count", 64'(pkt_sent_count), 64'd7);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("clr_err", 64'(err_timeout), 64'h0);

    // Timeout while clr_err is held: set wins on that edge
    resp    = 4'b1110;
    clr_err = 1'b1;
    send(64'h7777_0000_0000_0007, 0);
    repeat (17) @(negedge clk);
    chk("set_wins", 64'(err_timeout), 64'h1);
    @(negedge clk);
    chk("clr_after_set", 64'(err_timeout), 64'h0);
    clr_err = 1'b0;
    resp    = 4'b1111;

    // Reset pulsed during ACK on lane 1
    resp = 4'b1101;
    send(64'h8888_0000_0000_0008, 1);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_load",  64'(tx_load), 64'h0);
    chk("arst_data",  tx_data, 64'h0);
    chk("arst_count", 64'(pkt_sent_count), 64'h0);
    chk("arst_err",   64'(err_timeout), 64'h0);
    chk("arst_ready", 64'(pkt_ready), 64'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    resp    = 4'b1111;
    send(64'h9999_0000_0000_0009, 0);
    settle();
    chk("post_rst_count", 64'(pkt_sent_count), 64'd1);

    // Lanes 0..2 busy from rr_ptr 0: grant lane 3, pointer wraps to 0
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    hold_busy = 4'b0111;
    send(64'hAAAA_0000_0000_000A, 3);
    settle();
    hold_busy = 4'b0000;
    send(64'hBBBB_0000_0000_000B, 0);
    settle();
    chk("wrap_count", 64'(pkt_sent_count), 64'd2);

    chk("sb_drained", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
